vending_machine_multi: RTL and testbench

Parametrised successor to the two-coin vending FSM. It accepts 5/10/20 Rs coins and accumulates credit in 5 Rs units up to a configurable price. It dispenses with exact change, refunds on cancel or inactivity timeout, and tracks product stock with sold-out handling. It sits directly behind the coin acceptor and drives the dispense solenoid and change hopper.

---
 rtl/vending_machine_multi.sv | 156 +++++++++++++++
 tb/tb_vending_machine_multi.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/vending_machine_multi.sv
// Multi-coin vending controller: accumulates 5/10/20 Rs credit toward PRICE,
// vends with change, refunds on cancel or idle timeout, and tracks stock.
module vending_machine_multi #(
    parameter int PRICE     = 3,
    parameter int CREDIT_W  = 5,
    parameter int STOCK_MAX = 8,
    parameter int STOCK_W   = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          in,
    input  logic                cancel,
    input  logic                restock,
    output logic                out,
    output logic [CREDIT_W-1:0] change,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                sold_out
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [STOCK_W-1:0]  STOCK_TOP = STOCK_W'(STOCK_MAX);
    localparam logic [TW-1:0]       TIMER_END = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        SOLD_OUT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                out_q, out_d;
    logic [STOCK_W-1:0]  stock_q, stock_d;
    logic                sold_out_q, sold_out_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic [CREDIT_W-1:0] coin_v;
    logic [CREDIT_W-1:0] sum;
    logic                coin;
    logic                vend;

    always_comb begin
        case (in)
            2'b01:   coin_v = CREDIT_W'(1);
            2'b10:   coin_v = CREDIT_W'(2);
            2'b11:   coin_v = CREDIT_W'(4);
            default: coin_v = '0;
        endcase
        coin = (in != 2'b00);
        sum  = credit_q + coin_v;

        state_d  = state_q;
        credit_d = credit_q;
        change_d = '0;
        out_d    = 1'b0;
        timer_d  = timer_q;
        vend     = 1'b0;

        case (state_q)
            IDLE: begin
                if (coin) begin
                    if (coin_v >= PRICE_C) begin
                        out_d    = 1'b1;
                        change_d = coin_v - PRICE_C;
                        vend     = 1'b1;
                    end else begin
                        credit_d = coin_v;
                        state_d  = COLLECT;
                        timer_d  = '0;
                    end
                end
            end
            COLLECT: begin
                // cancel refunds any coin arriving alongside it rather than completing the sale
                if (cancel) begin
                    change_d = sum;
                    credit_d = '0;
                    state_d  = IDLE;
                    timer_d  = '0;
                end else if (coin) begin
                    if (sum >= PRICE_C) begin
                        out_d    = 1'b1;
                        change_d = sum - PRICE_C;
                        credit_d = '0;
                        vend     = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        credit_d = sum;
                    end
                    timer_d = '0;
                end else if (timer_q == TIMER_END) begin
                    change_d = credit_q;
                    credit_d = '0;
                    state_d  = IDLE;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SOLD_OUT: begin
                change_d = coin_v;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase

        stock_d = stock_q;
        if (restock) begin
            stock_d = STOCK_TOP;
        end else if (vend) begin
            stock_d = stock_q - STOCK_W'(1);
        end

        if (vend && !restock && stock_q == STOCK_W'(1)) begin
            state_d = SOLD_OUT;
        end
        if (restock && state_q == SOLD_OUT) begin
            state_d = IDLE;
        end

        sold_out_d = (stock_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            change_q   <= '0;
            out_q      <= 1'b0;
            stock_q    <= STOCK_TOP;
            sold_out_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            change_q   <= change_d;
            out_q      <= out_d;
            stock_q    <= stock_d;
            sold_out_q <= sold_out_d;
            timer_q    <= timer_d;
        end
    end

    assign out      = out_q;
    assign change   = change_q;
    assign credit   = credit_q;
    assign stock    = stock_q;
    assign sold_out = sold_out_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench for vending_machine_multi: the driver queues hand-computed
// per-cycle expectations, a monitor pops and compares them after each edge.
module tb_vending_machine_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] in = 2'b00;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic       out;
    logic [4:0] change;
    logic [4:0] credit;
    logic [3:0] stock;
    logic       sold_out;

    typedef struct {
        string      name;
        logic       out;
        logic [4:0] change;
        logic [4:0] credit;
        logic [3:0] stock;
        logic       sold_out;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done = 1'b0;

    vending_machine_multi #(
        .PRICE(3), .CREDIT_W(5), .STOCK_MAX(8), .STOCK_W(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .in(in), .cancel(cancel), .restock(restock),
        .out(out), .change(change), .credit(credit), .stock(stock),
        .sold_out(sold_out)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic r, input logic [1:0] c,
                        input logic can, input logic rs, input logic eo,
                        input int ech, input int ecr, input int est, input logic eso);
        exp_t e;
        @(negedge clk);
        rst = r; in = c; cancel = can; restock = rs;
        e.name = nm; e.out = eo; e.change = 5'(ech); e.credit = 5'(ecr);
        e.stock = 4'(est); e.sold_out = eso;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input int n, input int ecr, input int est, input logic eso);
        for (int i = 0; i < n; i++) step(nm, 0, 2'b00, 0, 0, 0, 0, ecr, est, eso);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (out !== e.out || change !== e.change || credit !== e.credit ||
                    stock !== e.stock || sold_out !== e.sold_out) begin
                    errors++;
                    $display("FAIL %s: got out=%0b change=%0d credit=%0d stock=%0d sold_out=%0b, want out=%0b change=%0d credit=%0d stock=%0d sold_out=%0b",
                             e.name, out, change, credit, stock, sold_out,
                             e.out, e.change, e.credit, e.stock, e.sold_out);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        // reset held two cycles
        step("reset0", 1, 2'b00, 0, 0, 0, 0, 0, 8, 0);
        step("reset1", 1, 2'b00, 0, 0, 0, 0, 0, 8, 0);

        // 5 + 5 + 10 against price 3 units
        step("c1", 0, 2'b01, 0, 0, 0, 0, 1, 8, 0);
        step("c2", 0, 2'b01, 0, 0, 0, 0, 2, 8, 0);
        step("c3_vend", 0, 2'b10, 0, 0, 1, 1, 0, 7, 0);

        // 20 from IDLE, then back-to-back fresh transaction ended by cancel+coin
        step("c20_vend", 0, 2'b11, 0, 0, 1, 1, 0, 6, 0);
        step("c10", 0, 2'b10, 0, 0, 0, 0, 2, 6, 0);
        step("cancel_coin", 0, 2'b10, 1, 0, 0, 4, 0, 6, 0);
        step("cancel_idle", 0, 2'b00, 1, 0, 0, 0, 0, 6, 0);

        // inactivity timeout: refund after the 16th edge past the coin
        step("to_coin", 0, 2'b01, 0, 0, 0, 0, 1, 6, 0);
        idle("to_wait", 15, 1, 6, 0);
        step("to_refund", 0, 2'b00, 0, 0, 0, 1, 0, 6, 0);
        step("to_after", 0, 2'b00, 0, 0, 0, 0, 0, 6, 0);

        // coin on the timeout cycle wins
        step("tw_coin", 0, 2'b01, 0, 0, 0, 0, 1, 6, 0);
        idle("tw_wait", 15, 1, 6, 0);
        step("tw_late_coin", 0, 2'b01, 0, 0, 0, 0, 2, 6, 0);
        step("tw_wait2", 0, 2'b00, 0, 0, 0, 0, 2, 6, 0);
        step("tw_cancel", 0, 2'b00, 1, 0, 0, 2, 0, 6, 0);

        // restock, then drain all eight items
        step("restock", 0, 2'b00, 0, 1, 0, 0, 0, 8, 0);
        for (int i = 7; i >= 0; i--)
            step("drain", 0, 2'b11, 0, 0, 1, 1, 0, i, (i == 0));
        step("so_coin", 0, 2'b10, 0, 0, 0, 2, 0, 0, 1);
        step("so_cancel", 0, 2'b00, 1, 0, 0, 0, 0, 0, 1);
        step("so_restock_coin", 0, 2'b01, 0, 1, 0, 1, 0, 8, 0);
        step("post_restock_vend", 0, 2'b11, 0, 0, 1, 1, 0, 7, 0);
        step("vend_with_restock", 0, 2'b11, 0, 1, 1, 1, 0, 8, 0);

        // reset mid-transaction discards credit without refund
        step("mr_coin", 0, 2'b10, 0, 0, 0, 0, 2, 8, 0);
        step("mr_rst", 1, 2'b01, 1, 0, 0, 0, 0, 8, 0);
        step("mr_after", 0, 2'b00, 0, 0, 0, 0, 0, 8, 0);
        step("mr_after2", 0, 2'b00, 0, 0, 0, 0, 0, 8, 0);

        @(negedge clk);
        in = 2'b00; cancel = 1'b0; restock = 1'b0; rst = 1'b0;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: %0d entries left, want 0", q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        if (!done) begin
            $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
            $fatal(1, "timeout");
        end
    end

endmodule
